score_timer_display: RTL and testbench



---
 rtl/score_timer_display.sv | 159 +++++++++++++++
 tb/tb_score_timer_display.sv | 134 +++++++++++++
 2 files changed

// File: rtl/score_timer_display.sv
// score_timer_display: BCD-converts score/timer and drives the DE2 seven-segment displays
//   clk, rst_n          : 50 MHz clock, asynchronous active-low reset
//   score[13:0]         : binary score, saturated to 9999 for display
//   timer[5:0]          : binary seconds remaining
//   speed_level[1:0]    : speed digit source
//   game_over           : enables score blinking
//   hex0..hex3          : score ones..thousands (leading zeros blanked, blinks after game over)
//   hex4                : speed digit, hex5 always blank, hex6/hex7 timer ones/tens
//   busy                : conversion in progress
module score_timer_display #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] score,
    input  logic [5:0]  timer,
    input  logic [1:0]  speed_level,
    input  logic        game_over,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy
);
    localparam int CW = $clog2(BLINK_CYCLES) > 0 ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [13:0]     snap_s_q, snap_s_d;
    logic [5:0]      snap_t_q, snap_t_d;
    logic [3:0]      k_q, k_d;
    logic [15:0]     sbcd_q, sbcd_d;
    logic [7:0]      tbcd_q, tbcd_d;
    logic [3:0][6:0] sseg_q, sseg_d;
    logic [1:0][6:0] tseg_q, tseg_d;
    logic [6:0]      spd_q, spd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dark_q, dark_d;
    logic [13:0]     score_sat;
    logic            wrap;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = BLANK;
        endcase
    endfunction

    // double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [15:0] adj(input logic [15:0] v);
        adj = v;
        for (int i = 0; i < 4; i++)
            if (v[4*i+:4] >= 4'd5) adj[4*i+:4] = v[4*i+:4] + 4'd3;
    endfunction

    // snapshot holds the saturated score, so compare against the saturated input
    assign score_sat = score > 14'd9999 ? 14'd9999 : score;
    assign wrap      = cnt_q == CW'(BLINK_CYCLES - 1);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        snap_s_d = snap_s_q;
        snap_t_d = snap_t_q;
        k_d      = k_q;
        sbcd_d   = sbcd_q;
        tbcd_d   = tbcd_q;
        sseg_d   = sseg_q;
        tseg_d   = tseg_q;
        case (state_q)
            IDLE: if (!valid_q || score_sat != snap_s_q || timer != snap_t_q) begin
                snap_s_d = score_sat;
                snap_t_d = timer;
                valid_d  = 1'b1;
                sbcd_d   = '0;
                tbcd_d   = '0;
                k_d      = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                sbcd_d = (adj(sbcd_q) << 1) | 16'(snap_s_q[4'd13 - k_q]);
                // the 6 timer bits ride along in the last 6 of the 14 iterations
                if (k_q >= 4'd8) tbcd_d = 8'(adj({8'd0, tbcd_q}) << 1) | 8'(snap_t_q[3'(4'd13 - k_q)]);
                k_d = k_q + 4'd1;
                if (k_q == 4'd13) state_d = DONE;
            end
            DONE: begin
                sseg_d[0] = seg(sbcd_q[3:0]);
                sseg_d[1] = sbcd_q[15:4]  == '0 ? BLANK : seg(sbcd_q[7:4]);
                sseg_d[2] = sbcd_q[15:8]  == '0 ? BLANK : seg(sbcd_q[11:8]);
                sseg_d[3] = sbcd_q[15:12] == '0 ? BLANK : seg(sbcd_q[15:12]);
                tseg_d    = {seg(tbcd_q[7:4]), seg(tbcd_q[3:0])};
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign spd_d  = speed_level == 2'd0 ? 7'h79 : speed_level == 2'd1 ? 7'h24 :
                    speed_level == 2'd2 ? 7'h30 : 7'h3F;
    assign cnt_d  = !game_over || wrap ? '0 : cnt_q + CW'(1);
    assign dark_d = game_over && (dark_q ^ wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            snap_s_q <= '0;
            snap_t_q <= '0;
            k_q      <= '0;
            sbcd_q   <= '0;
            tbcd_q   <= '0;
            sseg_q   <= {4{BLANK}};
            tseg_q   <= {2{BLANK}};
            spd_q    <= BLANK;
            cnt_q    <= '0;
            dark_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            snap_s_q <= snap_s_d;
            snap_t_q <= snap_t_d;
            k_q      <= k_d;
            sbcd_q   <= sbcd_d;
            tbcd_q   <= tbcd_d;
            sseg_q   <= sseg_d;
            tseg_q   <= tseg_d;
            spd_q    <= spd_d;
            cnt_q    <= cnt_d;
            dark_q   <= dark_d;
        end
    end

    assign hex0 = dark_q ? BLANK : sseg_q[0];
    assign hex1 = dark_q ? BLANK : sseg_q[1];
    assign hex2 = dark_q ? BLANK : sseg_q[2];
    assign hex3 = dark_q ? BLANK : sseg_q[3];
    assign hex4 = spd_q;
    assign hex5 = BLANK;
    assign hex6 = tseg_q[0];
    assign hex7 = tseg_q[1];
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_score_timer_display.sv
// tb_score_timer_display: directed self-checking bench for score_timer_display
module tb_score_timer_display;
    localparam logic [6:0] B = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] score = '0;
    logic [5:0]  timer = '0;
    logic [1:0]  speed_level = '0;
    logic        game_over = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy;
    logic [27:0] sdisp;
    logic [6:0]  sp [4] = '{7'h79, 7'h24, 7'h30, 7'h3F};
    logic [6:0]  prev;
    int          total = 0;
    int          bad = 0;

    score_timer_display #(.BLINK_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .score(score), .timer(timer),
        .speed_level(speed_level), .game_over(game_over),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7), .busy(busy)
    );

    always #5 clk = ~clk;
    assign sdisp = {hex3, hex2, hex1, hex0};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // new score applied in IDLE: display must hold the old value until trigger+15
    task automatic conv(input logic [13:0] sc, input logic [27:0] old, input logic [27:0] exp, input string tag);
        score = sc;
        step(1);
        for (int i = 0; i < 15; i++) begin
            chk({tag, "_hold"}, sdisp, old);
            chk({tag, "_busy"}, 28'(busy), 28'd1);
            step(1);
        end
        chk({tag, "_idle"}, 28'(busy), 28'd0);
        chk({tag, "_new"}, sdisp, exp);
    endtask

    initial begin
        timer = 6'd60;
        step(3);
        chk("rst_score", sdisp, {B, B, B, B});
        chk("rst_timer", 28'({hex7, hex6}), 28'({B, B}));
        chk("rst_hex4", 28'(hex4), 28'(B));
        chk("rst_busy", 28'(busy), 28'd0);

        rst_n = 1'b1;
        step(1);
        chk("first_hex4", 28'(hex4), 28'h79);
        for (int i = 0; i < 15; i++) begin
            chk("first_busy", 28'(busy), 28'd1);
            chk("first_blank", sdisp, {B, B, B, B});
            chk("first_tblank", 28'({hex7, hex6}), 28'({B, B}));
            step(1);
        end
        chk("first_idle", 28'(busy), 28'd0);
        chk("first_score", sdisp, {B, B, B, 7'h40});
        chk("first_timer", 28'({hex7, hex6}), 28'({7'h02, 7'h40}));

        conv(14'd1234, {B, B, B, 7'h40}, {7'h79, 7'h24, 7'h30, 7'h19}, "s1234");
        conv(14'd12000, {7'h79, 7'h24, 7'h30, 7'h19}, {4{7'h10}}, "sat12000");
        score = 14'd9999;
        step(20);
        chk("sat9999_busy", 28'(busy), 28'd0);
        chk("sat9999", sdisp, {4{7'h10}});

        score = 14'd5;
        timer = 6'd9;
        step(1);
        step(2);
        score = 14'd7;
        step(13);
        chk("mid_5", sdisp, {B, B, B, 7'h12});
        chk("timer09", 28'({hex7, hex6}), 28'({7'h40, 7'h10}));
        step(15);
        chk("mid_5_hold", sdisp, {B, B, B, 7'h12});
        step(1);
        chk("mid_7", sdisp, {B, B, B, 7'h78});

        conv(14'd42, {B, B, B, 7'h78}, {B, B, 7'h19, 7'h24}, "s42");
        game_over = 1'b1;
        chk("blink_start", 28'({hex1, hex0}), 28'({7'h19, 7'h24}));
        for (int j = 1; j <= 12; j++) begin
            step(1);
            chk($sformatf("blink_%0d", j), 28'({hex1, hex0}),
                ((j / 4) % 2) == 1 ? 28'({B, B}) : 28'({7'h19, 7'h24}));
            chk("blink_timer", 28'({hex7, hex6}), 28'({7'h40, 7'h10}));
        end
        game_over = 1'b0;
        step(1);
        chk("blink_off", 28'({hex1, hex0}), 28'({7'h19, 7'h24}));

        prev = 7'h79;
        for (int v = 0; v < 4; v++) begin
            speed_level = 2'(v);
            chk("spd_pre", 28'(hex4), 28'(prev));
            step(1);
            chk($sformatf("spd_%0d", v), 28'(hex4), 28'(sp[v]));
            chk("hex5", 28'(hex5), 28'(B));
            prev = sp[v];
        end

        score = 14'd100;
        step(6);
        chk("abort_busy_pre", 28'(busy), 28'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 28'(busy), 28'd0);
        chk("abort_score", sdisp, {B, B, B, B});
        chk("abort_hex4", 28'(hex4), 28'(B));
        step(2);
        rst_n = 1'b1;
        conv(14'd100, {B, B, B, B}, {B, 7'h79, 7'h40, 7'h40}, "s100");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
